// File: rtl/lane_distributor_pkg.sv
// Shared widths and mode encodings for the lane distributor.
package lane_distributor_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned DEST_W = $clog2(LANES);

  localparam logic [MODE_W-1:0] MODE_UNI   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BCAST = 2'b11;

endpackage

// File: rtl/lane_distributor_lane_slot.sv
// One-entry lane buffer: data register plus valid flag with load/drain handling.
module lane_slot
  import lane_distributor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              free
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  // A draining lane can be refilled in the same cycle.
  assign free  = ~valid_q | drain;
  assign data  = data_q;
  assign valid = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= load_data;
        valid_q <= 1'b1;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lane_distributor.sv
// Distributes input words to four single-entry lanes in unicast or broadcast mode.
module lane_distributor
  import lane_distributor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEST_W-1:0] dest,
  input  logic [MODE_W-1:0] mode,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [LANES-1:0]  out_valid,
  input  logic [LANES-1:0]  out_ready,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic              err
);

  logic [LANES-1:0]  lane_free;
  logic [LANES-1:0]  lane_load;
  logic [DATA_W-1:0] lane_data [LANES];
  logic              is_uni;
  logic              is_bcast;
  logic              fire;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  assign is_uni   = (mode == MODE_UNI);
  assign is_bcast = (mode == MODE_BCAST);

  // Invalid modes always accept so the word can be dropped and flagged.
  always_comb begin
    in_ready = 1'b1;
    if (is_uni) begin
      in_ready = lane_free[dest];
    end else if (is_bcast) begin
      in_ready = &lane_free;
    end
  end

  assign fire = in_valid & in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_load[i] = fire & (is_bcast | (is_uni & (dest == DEST_W'(i))));

    lane_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (lane_load[i]),
      .load_data (in_data),
      .drain     (out_ready[i]),
      .data      (lane_data[i]),
      .valid     (out_valid[i]),
      .free      (lane_free[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= fire & ~is_uni & ~is_bcast;
      if (fire && (is_uni || is_bcast) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out0       = lane_data[0];
  assign out1       = lane_data[1];
  assign out2       = lane_data[2];
  assign out3       = lane_data[3];
  assign accept_cnt = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lane_distributor.sv
// Directed bench for lane_distributor with hand-computed expectations.
module tb_lane_distributor;
  import lane_distributor_pkg::*;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DEST_W-1:0] dest;
  logic [MODE_W-1:0] mode;
  logic [DATA_W-1:0] out0, out1, out2, out3;
  logic [LANES-1:0]  out_valid;
  logic [LANES-1:0]  out_ready;
  logic [CNT_W-1:0]  accept_cnt;
  logic              err;

  int n_checks;
  int n_errors;

  lane_distributor dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dest       (dest),
    .mode       (mode),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    in_data   = 4'd7;
    in_valid  = 1'b1;
    dest      = 2'd0;
    mode      = MODE_UNI;
    out_ready = 4'b0000;

    // Reset held with a pending unicast transfer.
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_cnt", 32'(accept_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out0", 32'(out0), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();

    // Unicast to lane 2.
    in_data = 4'd9; dest = 2'd2; mode = MODE_UNI; in_valid = 1'b1;
    #1 check("uni_ready", 32'(in_ready), 32'd1);
    step();
    check("uni_out2", 32'(out2), 32'd9);
    check("uni_valid", 32'(out_valid), 32'b0100);
    check("uni_cnt", 32'(accept_cnt), 32'd1);
    in_data = 4'd4;
    #1 check("uni_full_ready", 32'(in_ready), 32'd0);
    step();
    check("uni_no_overwrite", 32'(out2), 32'd9);
    check("uni_blocked_cnt", 32'(accept_cnt), 32'd1);

    // Fill lane 1, then drain lane 2 so only lane 1 is occupied.
    in_data = 4'd6; dest = 2'd1;
    step();
    check("fill1_valid", 32'(out_valid), 32'b0110);
    in_valid = 1'b0; out_ready = 4'b0100;
    step();
    check("drain2_valid", 32'(out_valid), 32'b0010);
    check("drain2_hold", 32'(out2), 32'd9);

    // Broadcast blocked by lane 1, then released.
    out_ready = 4'b0000; mode = MODE_BCAST; in_data = 4'd5; in_valid = 1'b1;
    #1 check("bc_blocked_ready", 32'(in_ready), 32'd0);
    step();
    check("bc_blocked_valid", 32'(out_valid), 32'b0010);
    check("bc_blocked_out0", 32'(out0), 32'd0);
    check("bc_blocked_cnt", 32'(accept_cnt), 32'd2);
    out_ready = 4'b0010;
    #1 check("bc_ready", 32'(in_ready), 32'd1);
    step();
    check("bc_valid", 32'(out_valid), 32'b1111);
    check("bc_lanes", {16'h0, out3, out2, out1, out0}, 32'h5555);
    check("bc_cnt", 32'(accept_cnt), 32'd3);

    // Clear all lanes, then drain-and-refill on lane 0.
    in_valid = 1'b0; out_ready = 4'b1111;
    step();
    check("clear_valid", 32'(out_valid), 32'b0000);
    out_ready = 4'b0000; mode = MODE_UNI; dest = 2'd0; in_data = 4'd3; in_valid = 1'b1;
    step();
    check("l0_out0", 32'(out0), 32'd3);
    out_ready = 4'b0001; in_data = 4'd12;
    #1 check("refill_ready", 32'(in_ready), 32'd1);
    step();
    check("refill_out0", 32'(out0), 32'd12);
    check("refill_valid", 32'(out_valid), 32'b0001);
    check("refill_cnt", 32'(accept_cnt), 32'd5);
    in_valid = 1'b0;
    step();
    check("drain0_valid", 32'(out_valid), 32'b0000);
    check("drain0_hold", 32'(out0), 32'd12);

    // Invalid mode: dropped, err pulses for one cycle.
    out_ready = 4'b0000; mode = 2'b01; in_data = 4'd15; in_valid = 1'b1;
    #1 check("inv_ready", 32'(in_ready), 32'd1);
    step();
    check("inv_err", 32'(err), 32'd1);
    check("inv_cnt", 32'(accept_cnt), 32'd5);
    check("inv_valid", 32'(out_valid), 32'b0000);
    check("inv_out0", 32'(out0), 32'd12);
    in_valid = 1'b0;
    step();
    check("inv_err_clear", 32'(err), 32'd0);

    // Saturation with all consumers ready.
    out_ready = 4'b1111; mode = MODE_UNI; in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      dest    = DEST_W'(i);
      in_data = DATA_W'(i);
      step();
    end
    check("sat_cnt", 32'(accept_cnt), 32'd255);
    check("sat_valid", 32'(out_valid), 32'b1000);

    // Mid-stream reset clears asynchronously.
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'b0000);
    check("arst_cnt", 32'(accept_cnt), 32'd0);
    check("arst_out3", 32'(out3), 32'd0);
    step();
    check("arst_hold_valid", 32'(out_valid), 32'b0000);
    out_ready = 4'b0000; dest = 2'd3; in_data = 4'd10;
    #2 rst = 1'b1;
    step();
    check("post_rst_out3", 32'(out3), 32'd10);
    check("post_rst_valid", 32'(out_valid), 32'b1000);
    check("post_rst_cnt", 32'(accept_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
